// File: rtl/event_counter_pkg.sv
// event_counter_pkg: readout state type and the shared saturate/wrap counter step function
package event_counter_pkg;
  typedef enum logic {IDLE, SEND} rd_state_t;
  function automatic int next_count(int cur, logic add, logic sub, logic wrap, int max);
    if (add && !sub) return cur == max - 1 ? (wrap ? 0 : cur) : cur + 1;
    if (sub && !add) return cur == 0 ? (wrap ? max - 1 : 0) : cur - 1;
    return cur;
  endfunction
endpackage

// File: rtl/multi_channel_event_counter_if.sv
// multi_channel_event_counter_if: readout stream (data_out, ch_out, valid_out, last_out from master; ready_in from slave)
interface multi_channel_event_counter_if #(
  parameter int WIDTH = 4,
  parameter int CHW = 3
);
  logic [WIDTH-1:0] data_out;
  logic [CHW-1:0] ch_out;
  logic valid_out;
  logic last_out;
  logic ready_in;
  modport master(output data_out, ch_out, valid_out, last_out, input ready_in);
  modport slave(input data_out, ch_out, valid_out, last_out, output ready_in);
endinterface

// File: rtl/event_counter_ch.sv
// event_counter_ch: one up/down counter with saturate/wrap and registered threshold flag (clk, rst, clear, add, sub -> count, above)
module event_counter_ch
  import event_counter_pkg::*;
#(
  parameter int MAX_COUNT = 16,
  parameter int START_VAL = 15,
  parameter int WRAP = 0,
  parameter int THRESH = 8,
  localparam int WIDTH = $clog2(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             add,
  input  logic             sub,
  output logic [WIDTH-1:0] count,
  output logic             above
);
  logic [WIDTH-1:0] nxt;
  always_comb nxt = WIDTH'(next_count(int'(count), add, sub, WRAP != 0, MAX_COUNT));
  always_ff @(posedge clk) begin
    count <= rst || clear ? WIDTH'(START_VAL) : nxt;
    above <= rst || clear ? START_VAL >= THRESH : int'(nxt) >= THRESH;
  end
endmodule

// File: rtl/multi_channel_event_counter.sv
// multi_channel_event_counter: NUM_CH event counters with threshold flags and a snapshot readout stream (clk_in, rst_in, add/sub_evt_in, clear_in, snap_in -> count_out, above_out, busy_out, rd)
module multi_channel_event_counter
  import event_counter_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int MAX_COUNT = 16,
  parameter int START_VAL = 15,
  parameter int WRAP = 0,
  parameter int THRESH = 8,
  localparam int WIDTH = $clog2(MAX_COUNT),
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_CH-1:0]       add_evt_in,
  input  logic [NUM_CH-1:0]       sub_evt_in,
  input  logic                    clear_in,
  input  logic                    snap_in,
  output logic [NUM_CH*WIDTH-1:0] count_out,
  output logic [NUM_CH-1:0]       above_out,
  output logic                    busy_out,
  multi_channel_event_counter_if.master rd
);
  logic [NUM_CH-1:0][WIDTH-1:0] counts;
  logic [NUM_CH-1:0][WIDTH-1:0] shadow;
  logic [CHW-1:0] nxt_ch;
  rd_state_t state;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_counter_ch #(
      .MAX_COUNT(MAX_COUNT),
      .START_VAL(START_VAL),
      .WRAP(WRAP),
      .THRESH(THRESH)
    ) u_ch (
      .clk(clk_in),
      .rst(rst_in),
      .clear(clear_in),
      .add(add_evt_in[i]),
      .sub(sub_evt_in[i]),
      .count(counts[i]),
      .above(above_out[i])
    );
  end
  assign count_out = counts;
  assign busy_out = state != IDLE;
  assign nxt_ch = rd.ch_out + 1'b1;
  // ch_out doubles as the readout index; shadow is only written when leaving IDLE
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      rd.valid_out <= 1'b0;
      rd.last_out <= 1'b0;
      rd.data_out <= '0;
      rd.ch_out <= '0;
    end else if (state == IDLE) begin
      if (snap_in) begin
        shadow <= counts;
        state <= SEND;
        rd.valid_out <= 1'b1;
        rd.data_out <= counts[0];
        rd.ch_out <= '0;
        rd.last_out <= NUM_CH == 1;
      end
    end else if (rd.ready_in) begin
      if (rd.last_out) begin
        state <= IDLE;
        rd.valid_out <= 1'b0;
        rd.last_out <= 1'b0;
      end else begin
        rd.data_out <= shadow[nxt_ch];
        rd.ch_out <= nxt_ch;
        rd.last_out <= nxt_ch == CHW'(NUM_CH - 1);
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_event_counter.sv
// tb_multi_channel_event_counter: directed counter checks plus scoreboarded readout beats
module tb_multi_channel_event_counter;
  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] data;
    logic       last;
  } beat_t;
  logic clk = 0, rst = 1, clear = 0, snap = 0;
  logic [3:0] add = 0, sub = 0;
  logic [15:0] count;
  logic [3:0] above;
  logic busy;
  logic [1:0] aw = 0, sw = 0, am = 0, sm = 0;
  logic [7:0] cw, cm;
  logic [1:0] abw, abm;
  logic bw, bm;
  int vec = 0, err = 0;
  beat_t exp_q[$];
  always #5 clk = ~clk;
  multi_channel_event_counter_if #(.WIDTH(4), .CHW(2)) rd ();
  multi_channel_event_counter_if #(.WIDTH(4), .CHW(1)) rd_w ();
  multi_channel_event_counter_if #(.WIDTH(4), .CHW(1)) rd_m ();
  multi_channel_event_counter #(.NUM_CH(4), .MAX_COUNT(16), .START_VAL(15), .WRAP(0), .THRESH(8)) dut (
    .clk_in(clk), .rst_in(rst), .add_evt_in(add), .sub_evt_in(sub), .clear_in(clear), .snap_in(snap),
    .count_out(count), .above_out(above), .busy_out(busy), .rd(rd)
  );
  multi_channel_event_counter #(.NUM_CH(2), .MAX_COUNT(16), .START_VAL(15), .WRAP(1), .THRESH(8)) dut_w (
    .clk_in(clk), .rst_in(rst), .add_evt_in(aw), .sub_evt_in(sw), .clear_in(1'b0), .snap_in(1'b0),
    .count_out(cw), .above_out(abw), .busy_out(bw), .rd(rd_w)
  );
  multi_channel_event_counter #(.NUM_CH(2), .MAX_COUNT(10), .START_VAL(9), .WRAP(1), .THRESH(5)) dut_m (
    .clk_in(clk), .rst_in(rst), .add_evt_in(am), .sub_evt_in(sm), .clear_in(1'b0), .snap_in(1'b0),
    .count_out(cm), .above_out(abm), .busy_out(bm), .rd(rd_m)
  );
  task automatic chk(input string name, input int act, input int req);
    vec++;
    if (act != req) begin
      err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask
  function automatic int c(input int i);
    return int'(count[i*4 +: 4]);
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic evt(input logic [3:0] a, input logic [3:0] s, input int n);
    add = a;
    sub = s;
    repeat (n) cyc();
    add = 0;
    sub = 0;
  endtask
  task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
    exp_q.push_back({2'd0, d0, 1'b0});
    exp_q.push_back({2'd1, d1, 1'b0});
    exp_q.push_back({2'd2, d2, 1'b0});
    exp_q.push_back({2'd3, d3, 1'b1});
  endtask
  always @(negedge clk) begin
    if (rd.valid_out) begin
      if (exp_q.size() == 0) begin
        vec++;
        err++;
        $display("FAIL unexpected_beat: got ch %0d data %0d, required no beat", rd.ch_out, rd.data_out);
      end else begin
        chk("beat_ch", int'(rd.ch_out), int'(exp_q[0].ch));
        chk("beat_data", int'(rd.data_out), int'(exp_q[0].data));
        chk("beat_last", int'(rd.last_out), int'(exp_q[0].last));
        if (rd.ready_in) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    rd.ready_in = 1;
    rd_w.ready_in = 1;
    rd_m.ready_in = 1;
    repeat (2) cyc();
    rst = 0;
    chk("rst_count", int'(count), 16'hffff);
    chk("rst_above", int'(above), 4'hf);
    chk("rst_valid", int'(rd.valid_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_last", int'(rd.last_out), 0);
    chk("rst_data", int'(rd.data_out), 0);
    chk("rst_ch", int'(rd.ch_out), 0);
    evt(4'b0001, 0, 5);
    chk("sat_top", c(0), 15);
    evt(0, 4'b0001, 5);
    chk("sub5", c(0), 10);
    chk("above10", int'(above[0]), 1);
    evt(0, 4'b0001, 2);
    chk("above8", int'(above[0]), 1);
    evt(0, 4'b0001, 1);
    chk("sub_to7", c(0), 7);
    chk("above7", int'(above[0]), 0);
    evt(0, 4'b0001, 16);
    chk("sat_bottom", c(0), 0);
    evt(4'b0001, 0, 16);
    chk("add16", c(0), 15);
    aw = 2'b01;
    am = 2'b01;
    cyc();
    aw = 0;
    am = 0;
    chk("wrap_add", int'(cw[3:0]), 0);
    chk("wrap10_add", int'(cm[3:0]), 0);
    sw = 2'b01;
    sm = 2'b01;
    cyc();
    sw = 0;
    sm = 0;
    chk("wrap_sub", int'(cw[3:0]), 15);
    chk("wrap10_sub", int'(cm[3:0]), 9);
    evt(0, 4'b0010, 4);
    chk("ch1_sub4", c(1), 11);
    evt(4'b0010, 4'b0010, 3);
    chk("add_and_sub", c(1), 11);
    evt(0, 4'b0100, 3);
    chk("ch2_sub3", c(2), 12);
    clear = 1;
    evt(4'b0100, 0, 1);
    clear = 0;
    chk("clear_over_add", c(2), 15);
    chk("clear_ch1", c(1), 15);
    evt(0, 4'b0111, 8);
    evt(0, 4'b0101, 4);
    evt(0, 4'b0100, 3);
    chk("pre_snap", int'(count), 16'hf073);
    push_frame(4'd3, 4'd7, 4'd0, 4'd15);
    snap = 1;
    cyc();
    snap = 0;
    for (int k = 0; k < 4; k++) begin
      chk("busy_frame", int'(busy), 1);
      chk("last_frame", int'(rd.last_out), int'(k == 3));
      cyc();
    end
    chk("busy_after", int'(busy), 0);
    chk("valid_after", int'(rd.valid_out), 0);
    push_frame(4'd3, 4'd7, 4'd0, 4'd15);
    rd.ready_in = 0;
    snap = 1;
    cyc();
    snap = 0;
    add = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      rd.ready_in = k % 3 == 2;
      snap = k == 4;
      cyc();
    end
    add = 0;
    snap = 0;
    rd.ready_in = 1;
    chk("bp_live_ch0", c(0), 15);
    chk("bp_busy_after", int'(busy), 0);
    chk("bp_valid_after", int'(rd.valid_out), 0);
    push_frame(4'd15, 4'd7, 4'd0, 4'd15);
    snap = 1;
    cyc();
    snap = 0;
    cyc();
    rd.ready_in = 0;
    rst = 1;
    cyc();
    rst = 0;
    rd.ready_in = 1;
    exp_q.delete();
    chk("abort_valid", int'(rd.valid_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 16'hffff);
    push_frame(4'd15, 4'd15, 4'd15, 4'd15);
    snap = 1;
    cyc();
    snap = 0;
    chk("restart_ch", int'(rd.ch_out), 0);
    repeat (5) cyc();
    chk("q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
